denorm_shift: RTL and testbench
===============================

Name: denorm_shift

Overview:
- Sequential inverse of the leading-zero counter: takes a left-normalized 16-bit mantissa plus its 5-bit shift count and shifts it back right to restore fixed-point magnitude.
- Sits in the reciprocal/distance path, after normalize-and-lookup, before the fixed-point consumers.
- Iterative right shift of up to STEP bits per clock, with valid/ready handshakes on both sides.

Parameters:
STEP, 1, max bits shifted per clock; legal values 1, 2, 4, 8; any other value is a compile-time error.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  synchronous active-low reset
i_data  input  16  normalized mantissa to denormalize
i_cnt  input  5  right-shift amount (matches LZC output range 0..16)
i_valid  input  1  upstream request; i_data/i_cnt valid
o_ready  output  1  block can accept a request
o_data  output  16  denormalized result
o_valid  output  1  o_data valid
i_ready  input  1  downstream accepts o_data
o_busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk; reset_n is synchronous and active-low.
- Reset (reset_n low at a rising edge): state IDLE, o_data=0, o_valid=0, o_ready=1, o_busy=0, shift register and remaining count cleared. Reset mid-operation aborts immediately and drops any in-flight result.
- States:
  - IDLE: o_ready=1.
  - SHIFT: o_ready=0, o_busy=1.
  - DONE: o_valid=1, o_busy=1.
- Accept: at an edge where state=IDLE and i_valid=1 (edge E0):
  - load data register with i_data;
  - load rem = min(i_cnt, 16), so values 17..31 clamp to 16;
  - go to SHIFT.
  - i_valid while not IDLE is ignored; upstream must hold it until o_ready.
- SHIFT, at each edge:
  - s = min(STEP, rem); data = data >> s (zero fill); rem = rem - s.
  - If the new rem == 0, go to DONE.
  - rem==0 on entry gives s=0 and goes to DONE at E1.
- Latency: o_valid rises after edge E0 + max(1, ceil(min(i_cnt,16)/STEP)).
  - STEP=1: cnt=0 takes 1 cycle; cnt=16 takes 16 cycles.
  - STEP=4: cnt=16 takes 4 cycles.
- DONE:
  - o_data equals the shifted register and stays stable while o_valid=1.
  - At an edge with i_ready=1, go to IDLE and o_valid falls; no same-cycle re-accept.
  - Minimum request spacing is latency + 2 edges.
  - i_ready=0 holds DONE indefinitely with no data change.
- Arithmetic: logical right shift, unsigned.
  - cnt>=16 produces 0 (before rounding).
  - o_data changes only on a SHIFT→DONE transition; it is not updated during SHIFT. o_data is the output register and the working register is internal.
- o_busy = (state != IDLE). o_ready = (state == IDLE).

Optional Feature:
- Macro: DENORM_ROUND_EN.
- Defined:
  - Track the guard bit, i.e. the last bit shifted out (the bit at position cnt-1 of the original input).
  - On SHIFT→DONE, o_data = shifted + guard (round half up).
  - No overflow is possible, since any shift of 1 or more leaves the result at most 0x7FFF.
  - cnt=0 gives guard=0 (no change).
  - cnt>=16 gives guard = original bit 15 when cnt==16. For a clamped cnt>16, guard=0 (the input was shifted fully past).
  - Latency is unchanged.
- Not defined: plain truncation, no guard logic.

Test Plan:
- Reset/idle: STEP=1; hold reset_n=0 for 2 edges, then release → o_valid=0, o_data=0x0000, o_ready=1, o_busy=0; i_valid held low → state stays IDLE.
- Basic shift: STEP=1; i_data=0x8000, i_cnt=3 accepted at E0, i_ready=1 → o_valid first high after E3, o_data=0x1000; o_ready=1 again after E4.
- Zero and full: STEP=1; (0xABCD, 0) → o_data=0xABCD one cycle after accept. (0xFFFF, 16) → o_data=0x0000 after 16 cycles. (0xFFFF, 31) → clamps to 16 and gives the same result.
- Multi-bit step: STEP=4; (0xF000, 6) → shifts 4 then 2, o_valid after 2 cycles, o_data=0x03C0. (0x8000, 16) → o_data=0x0000 after 4 cycles.
- Backpressure and abort:
  - i_ready=0 for 5 cycles in DONE → o_data/o_valid stable and o_ready=0; raising i_ready → IDLE on the next edge.
  - A second i_valid during SHIFT is ignored.
  - reset_n=0 mid-SHIFT → IDLE with outputs 0 on the next edge.
- DENORM_ROUND_EN:
  - (0x8000, 16) → 0x0001.
  - (0x0003, 1) → 0x0002.
  - (0x0002, 1) → 0x0001.
  - With the macro undefined, the same inputs give 0x0000, 0x0001, 0x0001.

Source files
------------

// File: rtl/denorm_shift.sv
// -----------------------------------------------------------------------------
// denorm_shift
//
// Purpose:
//   Sequential inverse of the leading-zero counter. A left-normalized 16-bit
//   mantissa and its 5-bit shift count come in. The mantissa is shifted back
//   to the right by up to STEP bits per clock, which restores its fixed-point
//   magnitude. The block sits between normalize-and-lookup and the fixed-point
//   consumers in the reciprocal/distance path.
//
// Parameters:
//   STEP     max bits shifted per clock (1, 2, 4 or 8; other values fail
//            elaboration)
//
// Optional feature (compile-time macro):
//   DENORM_ROUND_EN  when defined, the last bit shifted out (guard) is added
//                    to the result on completion (round half up). When it is
//                    undefined, the result is plain truncation.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset_n  in   1   synchronous active-low reset
//   i_data   in  16   normalized mantissa
//   i_cnt    in   5   right-shift amount (0..16; 17..31 clamp to 16)
//   i_valid  in   1   request valid
//   o_ready  out  1   block idle and able to accept a request
//   o_data   out 16   denormalized result (registered)
//   o_valid  out  1   o_data valid
//   i_ready  in   1   downstream accepts o_data
//   o_busy   out  1   request in flight (SHIFT or DONE)
//
// Handshake:
//   Input side: a request transfers on a rising edge where i_valid && o_ready.
//     o_ready is high only in IDLE. The requester holds i_valid/i_data/i_cnt
//     until that edge. i_valid outside IDLE is ignored.
//   Output side: the result transfers on a rising edge where o_valid && i_ready.
//     o_data and o_valid stay stable until that edge, and the block then
//     returns to IDLE. It never re-accepts on the same edge.
//   The FSM state can be observed directly on the outputs:
//     IDLE  = o_ready
//     SHIFT = o_busy && !o_valid
//     DONE  = o_valid
// -----------------------------------------------------------------------------
module denorm_shift #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] i_data,
    input  logic [4:0]  i_cnt,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [15:0] o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy
);

    if (STEP != 1 && STEP != 2 && STEP != 4 && STEP != 8) begin : g_bad_step
        $error("denorm_shift: STEP must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] STEP_W   = 5'(STEP);
    localparam logic [4:0] CNT_FULL = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [15:0] data_q;        // working shift register
    logic [4:0]  rem_q;         // bits still to shift
    logic [15:0] o_data_q;      // output register, written only on SHIFT->DONE

    logic [4:0]  step_amt;
    logic [15:0] data_shifted;
    logic [4:0]  rem_next;
    logic [15:0] result;

    // Per-cycle shift amount: s = min(STEP, rem).
    always_comb begin
        step_amt     = (rem_q < STEP_W) ? rem_q : STEP_W;
        data_shifted = data_q >> step_amt;
        rem_next     = rem_q - step_amt;
    end

`ifdef DENORM_ROUND_EN
    logic       guard_q;
    logic       guard_next;
    logic [3:0] guard_idx;

    // The guard is the MSB of the bits dropped this cycle, at position s-1.
    // s never exceeds 8, so a 4-bit index covers it. When s == 0, the previous
    // guard is kept. That previous guard is 0 after accept, which covers cnt=0.
    always_comb begin
        guard_idx  = 4'(step_amt - 5'd1);
        guard_next = (step_amt != 5'd0) ? data_q[guard_idx] : guard_q;
        // Any shift of 1 or more leaves at most 0x7FFF, so this cannot overflow.
        result     = data_shifted + {15'd0, guard_next};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            guard_q <= 1'b0;
        end else if (state_q == IDLE && i_valid) begin
            guard_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            guard_q <= guard_next;
        end
    end
`else
    always_comb begin
        result = data_shifted;
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_valid)           state_d = SHIFT;
            SHIFT:   if (rem_next == 5'd0)  state_d = DONE;
            DONE:    if (i_ready)           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q   <= 16'd0;
            rem_q    <= 5'd0;
            o_data_q <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        // A count above 16 shifts the input fully out. Loading
                        // zero gives the same truncated result (0) and also
                        // makes the guard bit 0 for that case.
                        data_q <= (i_cnt > CNT_FULL) ? 16'd0 : i_data;
                        rem_q  <= (i_cnt > CNT_FULL) ? CNT_FULL : i_cnt;
                    end
                end
                SHIFT: begin
                    data_q <= data_shifted;
                    rem_q  <= rem_next;
                    if (rem_next == 5'd0) begin
                        o_data_q <= result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_valid = (state_q == DONE);
    assign o_data  = o_data_q;

endmodule

// File: tb/tb_denorm_shift.sv
// -----------------------------------------------------------------------------
// tb_denorm_shift
//
// Two instances are driven side by side: STEP=1 (index 0) and STEP=4
// (index 1). A driver pushes each expected {dut, latency, data} entry into
// exp_q when it issues the request. An independent negedge monitor pops the
// entry when o_valid rises. It also checks that o_data stays stable while
// o_valid is held. Expected values are hand-computed. Values that depend on
// rounding are selected through DENORM_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_denorm_shift;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [15:0] i_data_r  [2];
    logic [4:0]  i_cnt_r   [2];
    logic        i_valid_r [2];
    logic        i_ready_r [2];
    logic        o_ready_w [2];
    logic [15:0] o_data_w  [2];
    logic        o_valid_w [2];
    logic        o_busy_w  [2];

    denorm_shift #(.STEP(1)) u_dut_s1 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (i_data_r[0]),
        .i_cnt   (i_cnt_r[0]),
        .i_valid (i_valid_r[0]),
        .o_ready (o_ready_w[0]),
        .o_data  (o_data_w[0]),
        .o_valid (o_valid_w[0]),
        .i_ready (i_ready_r[0]),
        .o_busy  (o_busy_w[0])
    );

    denorm_shift #(.STEP(4)) u_dut_s4 (
        .clk     (clk),
        .reset_n (reset_n),
        .i_data  (i_data_r[1]),
        .i_cnt   (i_cnt_r[1]),
        .i_valid (i_valid_r[1]),
        .o_ready (o_ready_w[1]),
        .o_data  (o_data_w[1]),
        .o_valid (o_valid_w[1]),
        .i_ready (i_ready_r[1]),
        .o_busy  (o_busy_w[1])
    );

`ifdef DENORM_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Entry: [31] dut index, [30:16] latency in edges, [15:0] data.
    logic [31:0] exp_q[$];

    function automatic logic [15:0] pick(input logic [15:0] trunc_v, input logic [15:0] round_v);
        return ROUND ? round_v : trunc_v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc        [2];
    bit          tracking   [2];
    bit          prev_valid [2];
    logic [15:0] held       [2];

    always @(negedge clk) begin
        logic [31:0] e;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                tracking[k]   = 1'b0;
                prev_valid[k] = 1'b0;
                cyc[k]        = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (tracking[k]) cyc[k]++;
                if (o_valid_w[k] && !prev_valid[k]) begin
                    if (exp_q.size() == 0 || exp_q[0][31] != 1'(k)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output dut%0d: got data 0x%0h, expected no output",
                                 k, o_data_w[k]);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("data_dut%0d", k), {16'd0, o_data_w[k]}, {16'd0, e[15:0]});
                        chk($sformatf("latency_dut%0d", k), cyc[k], {17'd0, e[30:16]});
                    end
                    tracking[k] = 1'b0;
                    held[k]     = o_data_w[k];
                end else if (o_valid_w[k]) begin
                    chk($sformatf("hold_stable_dut%0d", k), {16'd0, o_data_w[k]}, {16'd0, held[k]});
                end
                // Accept happens at the next rising edge. Starting at -1 makes
                // cyc equal the number of edges after that accept edge.
                if (o_ready_w[k] && i_valid_r[k]) begin
                    tracking[k] = 1'b1;
                    cyc[k]      = -1;
                end
                prev_valid[k] = o_valid_w[k];
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int sel, input logic [15:0] d, input logic [4:0] c,
                          input logic [15:0] e, input int lat);
        int t = 0;
        while (!o_ready_w[sel] && t < 50) begin
            tick();
            t++;
        end
        chk("launch_ready", {31'd0, o_ready_w[sel]}, 32'd1);
        exp_q.push_back({1'(sel), 15'(lat), e});
        i_data_r[sel]  = d;
        i_cnt_r[sel]   = c;
        i_valid_r[sel] = 1'b1;
        tick();
        i_valid_r[sel] = 1'b0;
    endtask

    task automatic finish_req(input int sel, input int hold);
        int t = 0;
        while (!o_valid_w[sel] && t < 40) begin
            tick();
            t++;
        end
        chk("valid_seen", {31'd0, o_valid_w[sel]}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("bp_valid", {31'd0, o_valid_w[sel]}, 32'd1);
            chk("bp_ready", {31'd0, o_ready_w[sel]}, 32'd0);
        end
        i_ready_r[sel] = 1'b1;
        tick();
        chk("idle_valid", {31'd0, o_valid_w[sel]}, 32'd0);
        chk("idle_ready", {31'd0, o_ready_w[sel]}, 32'd1);
    endtask

    task automatic req(input int sel, input logic [15:0] d, input logic [4:0] c,
                       input logic [15:0] e, input int lat, input int hold);
        i_ready_r[sel] = (hold == 0);
        launch(sel, d, c, e, lat);
        finish_req(sel, hold);
    endtask

    task automatic chk_idle(input string name, input int sel);
        chk({name, "_valid"}, {31'd0, o_valid_w[sel]}, 32'd0);
        chk({name, "_data"},  {16'd0, o_data_w[sel]},  32'd0);
        chk({name, "_ready"}, {31'd0, o_ready_w[sel]}, 32'd1);
        chk({name, "_busy"},  {31'd0, o_busy_w[sel]},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_data_r[k]  = 16'd0;
            i_cnt_r[k]   = 5'd0;
            i_valid_r[k] = 1'b0;
            i_ready_r[k] = 1'b1;
        end

        // Reset / idle.
        tick();
        tick();
        chk_idle("reset_s1", 0);
        chk_idle("reset_s4", 1);
        reset_n = 1'b1;
        repeat (3) tick();
        chk_idle("idle_s1", 0);
        chk_idle("idle_s4", 1);

        // STEP=1 directed vectors.
        req(0, 16'h8000, 5'd3,  16'h1000, 3, 0);
        req(0, 16'hABCD, 5'd0,  16'hABCD, 1, 0);
        req(0, 16'hFFFF, 5'd16, pick(16'h0000, 16'h0001), 16, 0);
        req(0, 16'hFFFF, 5'd31, 16'h0000, 16, 0);
        req(0, 16'h1234, 5'd4,  16'h0123, 4, 0);
        req(0, 16'h8000, 5'd16, pick(16'h0000, 16'h0001), 16, 0);
        req(0, 16'h0003, 5'd1,  pick(16'h0001, 16'h0002), 1, 0);
        req(0, 16'h0002, 5'd1,  16'h0001, 1, 0);

        // STEP=4 directed vectors.
        req(1, 16'hF000, 5'd6,  16'h03C0, 2, 0);
        req(1, 16'h8000, 5'd16, pick(16'h0000, 16'h0001), 4, 0);
        req(1, 16'hABCD, 5'd5,  16'h055E, 2, 0);
        req(1, 16'h0006, 5'd2,  pick(16'h0001, 16'h0002), 1, 0);
        req(1, 16'hFFFF, 5'd31, 16'h0000, 4, 0);

        // Backpressure: hold DONE for 5 cycles.
        req(0, 16'h00F0, 5'd4, 16'h000F, 4, 5);

        // A second request during SHIFT is ignored.
        i_ready_r[0] = 1'b1;
        launch(0, 16'hFFFF, 5'd16, pick(16'h0000, 16'h0001), 16);
        i_data_r[0]  = 16'h1234;
        i_cnt_r[0]   = 5'd0;
        i_valid_r[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ignored_ready", {31'd0, o_ready_w[0]}, 32'd0);
        end
        i_valid_r[0] = 1'b0;
        finish_req(0, 0);

        // Reset in the middle of SHIFT drops the request.
        launch(0, 16'h8000, 5'd10, 16'h0020, 10);
        repeat (3) tick();
        chk("mid_busy", {31'd0, o_busy_w[0]}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk_idle("abort", 0);
        void'(exp_q.pop_back());
        reset_n = 1'b1;
        repeat (12) tick();
        chk("abort_no_valid", {31'd0, o_valid_w[0]}, 32'd0);

        // Recovery after the abort.
        req(0, 16'h4000, 5'd2, 16'h1000, 2, 0);

        repeat (2) tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
